// File: rtl/ex_div_seq_pkg.sv
// rtl/ex_div_seq_pkg.sv - shared encodings for the ex-stage divide sequencer
package ex_div_seq_pkg;

    typedef enum logic [1:0] {
        DIV_FREE = 2'b00,
        DIV_ON   = 2'b01,
        DIV_END  = 2'b10
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    localparam logic [7:0] EXE_DIV_OP  = 8'h1a;
    localparam logic [7:0] EXE_DIVU_OP = 8'h1b;
    localparam logic [7:0] EXE_REM_OP  = 8'h1c;
    localparam logic [7:0] EXE_REMU_OP = 8'h1d;

    typedef struct packed {
        logic is_signed;
        logic is_rem;
    } div_ctrl_t;

    // ex uses this to turn an aluop into the signed_i/rem_i pair
    function automatic div_ctrl_t decode_div_op(input logic [7:0] aluop);
        div_ctrl_t c;
        c.is_signed = (aluop == EXE_DIV_OP) || (aluop == EXE_REM_OP);
        c.is_rem    = (aluop == EXE_REM_OP) || (aluop == EXE_REMU_OP);
        return c;
    endfunction

endpackage

// File: rtl/ex_div_seq.sv
// rtl/ex_div_seq.sv - radix-2 restoring divide sequencer for DIV/DIVU/REM/REMU
module ex_div_seq
    import ex_div_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            annul_i,
    input  logic            signed_i,
    input  logic            rem_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] result_o,
    output logic            ready_o,
    output logic            stallreq_o
);

    localparam logic [XLEN-1:0] ONE  = 1;
    localparam logic [XLEN-1:0] LAST = XLEN - 1;

    div_state_e      state_q;
    logic [XLEN-1:0] cnt_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dsr_q;
    logic [XLEN-1:0] result_q;
    logic            ready_q;
    logic            rem_sel_q;
    logic            neg_quo_q;
    logic            neg_rem_q;

    logic            dvd_neg;
    logic            dsr_neg;
    logic [XLEN-1:0] dividend_abs;
    logic [XLEN-1:0] divisor_abs;
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] quo_d;
    logic [XLEN-1:0] rem_d;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    always_comb begin
        dvd_neg      = signed_i & dividend_i[XLEN-1];
        dsr_neg      = signed_i & divisor_i[XLEN-1];
        dividend_abs = dvd_neg ? (~dividend_i + ONE) : dividend_i;
        divisor_abs  = dsr_neg ? (~divisor_i + ONE) : divisor_i;

        // quo_q doubles as the dividend shift register: its MSB feeds the partial remainder
        rem_shift = {rem_q, quo_q[XLEN-1]};
        trial     = rem_shift - {1'b0, dsr_q};
        if (!trial[XLEN]) begin
            rem_d = trial[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_d = rem_shift[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
        end

        quo_fix = neg_quo_q ? (~quo_d + ONE) : quo_d;
        rem_fix = neg_rem_q ? (~rem_d + ONE) : rem_d;

        stallreq_o = !annul_i &&
                     (((state_q == DIV_FREE) && start_i) || (state_q == DIV_ON));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_FREE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dsr_q     <= '0;
            result_q  <= '0;
            ready_q   <= DIV_RESULT_NOT_READY;
            rem_sel_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            ready_q <= DIV_RESULT_NOT_READY;
            case (state_q)
                DIV_FREE: begin
                    if (start_i == DIV_START && !annul_i) begin
                        if (divisor_i == '0) begin
                            result_q <= rem_i ? dividend_i : '1;
                            ready_q  <= DIV_RESULT_READY;
                            state_q  <= DIV_END;
                        end else begin
                            quo_q     <= dividend_abs;
                            rem_q     <= '0;
                            dsr_q     <= divisor_abs;
                            rem_sel_q <= rem_i;
                            neg_quo_q <= dvd_neg ^ dsr_neg;
                            neg_rem_q <= dvd_neg;
                            cnt_q     <= '0;
                            state_q   <= DIV_ON;
                        end
                    end
                end
                DIV_ON: begin
                    if (annul_i) begin
                        state_q <= DIV_FREE;
                    end else begin
                        quo_q <= quo_d;
                        rem_q <= rem_d;
                        cnt_q <= cnt_q + ONE;
                        if (cnt_q == LAST) begin
                            result_q <= rem_sel_q ? rem_fix : quo_fix;
                            ready_q  <= DIV_RESULT_READY;
                            state_q  <= DIV_END;
                        end
                    end
                end
                DIV_END: begin
                    state_q <= DIV_FREE;
                end
                default: begin
                    state_q <= DIV_FREE;
                end
            endcase
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_ex_div_seq.sv
// tb/tb_ex_div_seq.sv - directed vector bench for ex_div_seq
module tb_ex_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic        signed_i;
    logic        rem_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic [31:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int checks = 0;
    int errors = 0;

    ex_div_seq #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .annul_i    (annul_i),
        .signed_i   (signed_i),
        .rem_i      (rem_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .stallreq_o (stallreq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sgn;
        logic        rem;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input logic s, input logic r, input logic [31:0] a, input logic [31:0] b);
        start_i    = 1'b1;
        signed_i   = s;
        rem_i      = r;
        dividend_i = a;
        divisor_i  = b;
    endtask

    // Called in the issue cycle (after inputs settle); start_i is held until ready_o appears.
    task automatic await_done(input string name, input logic [31:0] exp, input int lat);
        int  seen;
        bit  stall_ok;
        seen     = -1;
        stall_ok = (stallreq_o === 1'b1);
        for (int k = 1; k <= 40 && seen < 0; k++) begin
            @(negedge clk);
            if (ready_o === 1'b1) begin
                seen = k;
                check({name, " result"}, result_o, exp);
                if (stallreq_o !== 1'b0) stall_ok = 0;
                start_i = 1'b0;
            end else if (stallreq_o !== 1'b1) begin
                stall_ok = 0;
            end
        end
        start_i = 1'b0;
        check({name, " latency"}, 32'(seen), 32'(lat));
        check({name, " stall window"}, 32'(stall_ok), 32'd1);
        @(negedge clk);
        check({name, " ready single pulse"}, 32'(ready_o), 32'd0);
        check({name, " idle stall"}, 32'(stallreq_o), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit no_ready;

        vecs[0]  = '{"divu_100_7",     1'b0, 1'b0, 32'd100,        32'd7,          32'd14,         33};
        vecs[1]  = '{"remu_100_7",     1'b0, 1'b1, 32'd100,        32'd7,          32'd2,          33};
        vecs[2]  = '{"div_m7_2",       1'b1, 1'b0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
        vecs[3]  = '{"rem_m7_2",       1'b1, 1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
        vecs[4]  = '{"divu_5_0",       1'b0, 1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
        vecs[5]  = '{"rem_m5_0",       1'b1, 1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1};
        vecs[6]  = '{"div_m5_0",       1'b1, 1'b0, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  1};
        vecs[7]  = '{"div_ovf",        1'b1, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33};
        vecs[8]  = '{"rem_ovf",        1'b1, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33};
        vecs[9]  = '{"div_7_m2",       1'b1, 1'b0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33};
        vecs[10] = '{"rem_7_m2",       1'b1, 1'b1, 32'd7,          32'hFFFF_FFFE,  32'd1,          33};
        vecs[11] = '{"rem_m7_m2",      1'b1, 1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'hFFFF_FFFF,  33};
        vecs[12] = '{"div_m7_m2",      1'b1, 1'b0, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          33};
        vecs[13] = '{"divu_max_1",     1'b0, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33};
        vecs[14] = '{"remu_max_16",    1'b0, 1'b1, 32'hFFFF_FFFF,  32'd16,         32'hF,          33};
        vecs[15] = '{"divu_3_7",       1'b0, 1'b0, 32'd3,          32'd7,          32'd0,          33};
        vecs[16] = '{"remu_3_7",       1'b0, 1'b1, 32'd3,          32'd7,          32'd3,          33};
        vecs[17] = '{"divu_m7_2",      1'b0, 1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  33};

        rst        = 1'b1;
        start_i    = 1'b0;
        annul_i    = 1'b0;
        signed_i   = 1'b0;
        rem_i      = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset ready", 32'(ready_o), 32'd0);
        check("reset result", result_o, 32'd0);
        check("reset stall", 32'(stallreq_o), 32'd0);

        // start while annul is high is not accepted
        @(negedge clk);
        issue(1'b0, 1'b0, 32'd5, 32'd0);
        annul_i = 1'b1;
        #1;
        check("annul idle stall", 32'(stallreq_o), 32'd0);
        @(negedge clk);
        check("annul idle no ready", 32'(ready_o), 32'd0);
        start_i = 1'b0;
        annul_i = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            issue(vecs[i].sgn, vecs[i].rem, vecs[i].a, vecs[i].b);
            #1;
            await_done(vecs[i].name, vecs[i].exp, vecs[i].lat);
        end

        // annul in the 10th ON cycle, then restart immediately
        @(negedge clk);
        issue(1'b0, 1'b0, 32'd100, 32'd7);
        #1;
        no_ready = 1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (ready_o !== 1'b0) no_ready = 0;
            if (k == 10) begin
                annul_i = 1'b1;
                start_i = 1'b0;
                #1;
                check("annul on stall", 32'(stallreq_o), 32'd0);
            end
        end
        @(negedge clk);
        if (ready_o !== 1'b0) no_ready = 0;
        check("annul no ready pulse", 32'(no_ready), 32'd1);
        annul_i = 1'b0;
        issue(1'b0, 1'b0, 32'd9, 32'd3);
        #1;
        await_done("annul_restart", 32'd3, 33);

        // reset mid-operation
        @(negedge clk);
        issue(1'b0, 1'b0, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        rst     = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("midop rst ready", 32'(ready_o), 32'd0);
        check("midop rst stall", 32'(stallreq_o), 32'd0);
        check("midop rst result", result_o, 32'd0);
        @(negedge clk);
        check("midop rst stays idle", 32'(ready_o | stallreq_o), 32'd0);

        // operand change after acceptance
        @(negedge clk);
        issue(1'b0, 1'b0, 32'd100, 32'd7);
        #1;
        fork
            await_done("latched_operands", 32'd14, 33);
            begin
                repeat (5) @(negedge clk);
                dividend_i = 32'd50;
                divisor_i  = 32'd3;
            end
        join

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
